branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 31 +++
 rtl/branch_predictor_counter2.sv | 27 ++
 rtl/branch_predictor.sv | 121 ++++++++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_pkg
// Shared definitions for the dual-slot branch predictor:
//   - BTB_ENTRIES : default number of direct-mapped BTB entries
//   - CNT_*       : 2-bit saturating direction counter encodings
//   - btb_index() : extracts the BTB index field pc[idx_w+1:2]
//   - btb_tag()   : extracts the BTB tag field pc[31:idx_w+2]
// Both helpers return a zero-extended 32-bit value; callers truncate it to
// the index/tag width that matches their BTB depth.
// ---------------------------------------------------------------------------
package branch_predictor_pkg;

    localparam int BTB_ENTRIES = 16;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    // Instructions are word aligned, so the two low bits never carry
    // information; the index starts right above them.
    function automatic logic [31:0] btb_index(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Everything above the index field forms the tag.
    function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/branch_predictor_counter2.sv
// ---------------------------------------------------------------------------
// bp_counter2
// Next-state logic of a 2-bit saturating direction counter.
// Ports:
//   cnt   (in,  2) current counter value
//   taken (in,  1) resolved branch direction
//   next  (out, 2) counter value after training with 'taken'
// ---------------------------------------------------------------------------
module bp_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] next
);

    // Move one step toward the observed direction, sticking at either end.
    always_comb begin
        next = cnt;
        if (taken && (cnt != CNT_ST)) begin
            next = cnt + 2'd1;
        end else if (!taken && (cnt != CNT_SNT)) begin
            next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direct-mapped branch target buffer with a 2-bit direction counter per
// entry, looked up for two consecutive fetch slots in the same cycle and
// trained by one resolved branch per cycle from the execute stage.
// Ports:
//   clk         (in,  1)  rising-edge clock
//   rst         (in,  1)  asynchronous active-low reset
//   pc1, pc2    (in,  32) fetch slot addresses (pc2 = pc1 + 4)
//   pre_branch1 (out, 1)  slot 1 predicted taken
//   pre_branch2 (out, 1)  slot 2 predicted taken (squashed by slot 1)
//   predict_pc1 (out, 32) slot 1 BTB target on hit, else 0
//   predict_pc2 (out, 32) slot 2 BTB target on hit, else 0
//   upd_valid   (in,  1)  a branch/jump resolved this cycle
//   upd_pc      (in,  32) address of the resolved instruction
//   upd_taken   (in,  1)  resolved direction
//   upd_target  (in,  32) resolved target (meaningful when taken)
// ---------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc1,
    input  logic [31:0] pc2,
    output logic        pre_branch1,
    output logic        pre_branch2,
    output logic [31:0] predict_pc1,
    output logic [31:0] predict_pc2,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    // BTB storage is kept in flip-flops so that two lookups and one write
    // can all happen in the same cycle.
    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_cnt    [ENTRIES];

    logic [IDX_W-1:0] w_idx1;
    logic [IDX_W-1:0] w_idx2;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_tag1;
    logic [TAG_W-1:0] w_tag2;
    logic [TAG_W-1:0] w_utag;
    logic             w_hit1;
    logic             w_hit2;
    logic             w_uhit;
    logic [1:0]       w_ucnt_next;
    logic             w_unused;

    // The alignment bits of every address are deliberately ignored.
    assign w_unused = &{1'b0, pc1[1:0], pc2[1:0], upd_pc[1:0]};

    // Split each address into its index and tag fields.
    assign w_idx1 = IDX_W'(btb_index(pc1, IDX_W));
    assign w_idx2 = IDX_W'(btb_index(pc2, IDX_W));
    assign w_uidx = IDX_W'(btb_index(upd_pc, IDX_W));
    assign w_tag1 = TAG_W'(btb_tag(pc1, IDX_W));
    assign w_tag2 = TAG_W'(btb_tag(pc2, IDX_W));
    assign w_utag = TAG_W'(btb_tag(upd_pc, IDX_W));

    // Lookups read registered state only, so an update landing on the same
    // entry becomes visible one cycle later, never combinationally.
    assign w_hit1 = r_valid[w_idx1] && (r_tag[w_idx1] == w_tag1);
    assign w_hit2 = r_valid[w_idx2] && (r_tag[w_idx2] == w_tag2);
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    // A taken prediction in slot 1 redirects fetch, so slot 2 is never
    // reported taken alongside it. Targets are reported on any hit.
    always_comb begin
        pre_branch1 = w_hit1 && r_cnt[w_idx1][1];
        pre_branch2 = w_hit2 && r_cnt[w_idx2][1] && !pre_branch1;
        predict_pc1 = w_hit1 ? r_target[w_idx1] : 32'd0;
        predict_pc2 = w_hit2 ? r_target[w_idx2] : 32'd0;
    end

    // Training value for the counter of the entry being updated.
    bp_counter2 u_cnt (
        .cnt   (r_cnt[w_uidx]),
        .taken (upd_taken),
        .next  (w_ucnt_next)
    );

    // Reset clears every entry to invalid with a weakly-not-taken counter.
    // A hit trains the counter (and refreshes the target when taken); a
    // taken miss replaces whatever was at that index; a not-taken miss
    // leaves the BTB alone so cold branches do not evict useful entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'd0;
                r_cnt[i]    <= CNT_WNT;
            end
        end else if (upd_valid) begin
            if (w_uhit) begin
                r_cnt[w_uidx] <= w_ucnt_next;
                if (upd_taken) begin
                    r_target[w_uidx] <= upd_target;
                end
            end else if (upd_taken) begin
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= upd_target;
                r_cnt[w_uidx]    <= CNT_WT;
            end
        end
    end

endmodule
